execute_stage: RTL

- Second stage of the 3-stage CPU. It consumes the decoded instruction, register data and control bits registered by the fetch/decode stage.
- It resolves operand forwarding, runs the ALU or an iterative multiplier, and maintains the NVZ flag register that feeds branch evaluation in fetch/decode.
- It registers results and control bits for the MEM/WB stage.
- It generates the pipeline stall for load-use hazards and multiply busy, and buffers its own instruction across stalls.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/ex_mul16.sv | 71 +++++++
 rtl/execute_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-stage CPU: opcode encodings, flag bit positions
// and the control bundle carried between pipeline stages.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_ADD     = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB     = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND     = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR      = 5'b00011;
    localparam logic [OPC_W-1:0] OP_XOR     = 5'b00100;
    localparam logic [OPC_W-1:0] OP_NOOP    = 5'b00101;
    localparam logic [OPC_W-1:0] OP_MUL     = 5'b00110;
    localparam logic [OPC_W-1:0] OP_BRANCH  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_IMML    = 5'b01000;
    localparam logic [OPC_W-1:0] OP_IMMH    = 5'b01001;
    localparam logic [OPC_W-1:0] OP_LOAD    = 5'b01010;
    localparam logic [OPC_W-1:0] OP_STORE   = 5'b01011;
    localparam logic [OPC_W-1:0] OP_DBLOAD  = 5'b01100;
    localparam logic [OPC_W-1:0] OP_DBSTORE = 5'b01101;

    // Bit positions inside the {N,V,Z} flag register.
    localparam int NVZ_N = 2;
    localparam int NVZ_V = 1;
    localparam int NVZ_Z = 0;

    typedef struct packed {
        logic             alu_to_reg;
        logic             mem_to_reg;
        logic             bus_to_reg;
        logic             mem_read;
        logic             mem_write;
        logic             bus_write;
        logic [REG_W-1:0] wb_addr;
    } exec_ctrl_t;

    localparam exec_ctrl_t CTRL_BUBBLE = '0;

    // Everything the execute stage needs to (re)issue one instruction.
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  sr1;
        logic [REG_W-1:0]  sr2;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic              alu_src;
        exec_ctrl_t        ctrl;
    } exec_instr_t;

    typedef enum logic {
        MUL_IDLE,
        MUL_BUSY
    } mul_state_e;

    function automatic logic updates_flags(input logic [OPC_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/ex_mul16.sv
// Iterative unsigned 16x16 shift-add multiplier returning the low 16 bits.
// The first partial product is taken on the start edge; done is high for one cycle.
module ex_mul16 import cpu_pkg::*; #(
    parameter int MUL_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int STEP  = DATA_W / MUL_CYCLES;
    localparam int CNT_W = $clog2(MUL_CYCLES);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q, b_q, acc_q;

    function automatic logic [DATA_W-1:0] partial(input logic [DATA_W-1:0] a,
                                                  input logic [STEP-1:0]   bits);
        logic [DATA_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < STEP; i++) begin
            if (bits[i]) sum = sum + (a << i);
        end
        return sum;
    endfunction

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start_i) state_d = MUL_BUSY;
            MUL_BUSY: if (cnt_q == '0) state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_i && state_q == MUL_IDLE) begin
                acc_q <= partial(a_i, b_i[STEP-1:0]);
                a_q   <= a_i << STEP;
                b_q   <= b_i >> STEP;
                cnt_q <= CNT_W'(MUL_CYCLES - 1);
            end else if (state_q == MUL_BUSY && cnt_q != '0) begin
                acc_q <= acc_q + partial(a_q, b_q[STEP-1:0]);
                a_q   <= a_q << STEP;
                b_q   <= b_q >> STEP;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign busy_o   = (state_q == MUL_BUSY);
    assign done_o   = (state_q == MUL_BUSY) && (cnt_q == '0);
    assign result_o = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU / iterative multiply, NVZ flags,
// load-use and multiply stalls with a one-entry hold buffer, EX/MEM register.
module execute_stage import cpu_pkg::*; #(
    parameter int MUL_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPC_W-1:0]  iOpcode,
    input  logic [DATA_W-1:0] iImm,
    input  logic [REG_W-1:0]  iSr1,
    input  logic [REG_W-1:0]  iSr2,
    input  logic [DATA_W-1:0] iData1,
    input  logic [DATA_W-1:0] iData2,
    input  logic              iAlutoReg,
    input  logic              iMemtoReg,
    input  logic              iBustoReg,
    input  logic [REG_W-1:0]  iWriteBackAddr,
    input  logic              iALUSrc,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iBusWrite,
    input  logic              iWbEn,
    input  logic [REG_W-1:0]  iWbAddr,
    input  logic [DATA_W-1:0] iWbData,
    output logic              oStall,
    output logic [2:0]        oNVZ,
    output logic [DATA_W-1:0] oAluResult,
    output logic [DATA_W-1:0] oStoreData,
    output logic              oAlutoReg,
    output logic              oMemtoReg,
    output logic              oBustoReg,
    output logic [REG_W-1:0]  oWriteBackAddr,
    output logic              oMemRead,
    output logic              oMemWrite,
    output logic              oBusWrite
);

    exec_instr_t       port_instr, src, hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    exec_ctrl_t        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] result_q, result_d, store_q, store_d;
    logic [2:0]        nvz_q, nvz_d;

    logic              ex_fwd, sr2_used, load_use, is_mul, stall;
    logic              mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_result, op_a, op_b, alu_b, alu_res, sum, diff;
    logic              ovf, flags_upd;

    always_comb begin
        port_instr                 = '0;
        port_instr.opcode          = iOpcode;
        port_instr.imm             = iImm;
        port_instr.sr1             = iSr1;
        port_instr.sr2             = iSr2;
        port_instr.data1           = iData1;
        port_instr.data2           = iData2;
        port_instr.alu_src         = iALUSrc;
        port_instr.ctrl.alu_to_reg = iAlutoReg;
        port_instr.ctrl.mem_to_reg = iMemtoReg;
        port_instr.ctrl.bus_to_reg = iBustoReg;
        port_instr.ctrl.mem_read   = iMemRead;
        port_instr.ctrl.mem_write  = iMemWrite;
        port_instr.ctrl.bus_write  = iBusWrite;
        port_instr.ctrl.wb_addr    = iWriteBackAddr;
    end

    assign src = hold_valid_q ? hold_q : port_instr;

    // EX/MEM forwards only pure ALU results; loads resolve through MEM/WB.
    assign ex_fwd = ctrl_q.alu_to_reg && !ctrl_q.mem_to_reg && !ctrl_q.bus_to_reg;

    always_comb begin
        op_a = src.data1;
        if (src.sr1 != '0 && ex_fwd && ctrl_q.wb_addr == src.sr1)
            op_a = result_q;
        else if (src.sr1 != '0 && iWbEn && iWbAddr == src.sr1)
            op_a = iWbData;

        op_b = src.data2;
        if (src.sr2 != '0 && ex_fwd && ctrl_q.wb_addr == src.sr2)
            op_b = result_q;
        else if (src.sr2 != '0 && iWbEn && iWbAddr == src.sr2)
            op_b = iWbData;
    end

    assign alu_b    = src.alu_src ? src.imm : op_b;
    assign sr2_used = !src.alu_src || src.opcode == OP_STORE || src.opcode == OP_DBSTORE;
    assign load_use = (ctrl_q.mem_to_reg || ctrl_q.bus_to_reg) && ctrl_q.wb_addr != '0 &&
                      (src.sr1 == ctrl_q.wb_addr || (sr2_used && src.sr2 == ctrl_q.wb_addr));

    assign is_mul    = (src.opcode == OP_MUL);
    assign mul_start = is_mul && !mul_busy && !load_use;
    assign stall     = load_use || mul_start || (mul_busy && !mul_done);
    assign oStall    = stall && rst_n;

    ex_mul16 #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mul_start),
        .a_i      (op_a),
        .b_i      (op_b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .result_o (mul_result)
    );

    assign sum  = op_a + alu_b;
    assign diff = op_a - alu_b;

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (src.opcode)
            OP_ADD: begin
                alu_res = sum;
                ovf     = (op_a[15] == alu_b[15]) && (sum[15] != op_a[15]);
            end
            OP_SUB: begin
                alu_res = diff;
                ovf     = (op_a[15] != alu_b[15]) && (diff[15] != op_a[15]);
            end
            OP_AND:   alu_res = op_a & alu_b;
            OP_OR:    alu_res = op_a | alu_b;
            OP_XOR:   alu_res = op_a ^ alu_b;
            OP_IMML:  alu_res = src.imm;
            OP_IMMH:  alu_res = {src.imm[15:8], op_a[7:0]};
            OP_LOAD, OP_STORE, OP_DBLOAD, OP_DBSTORE: alu_res = op_a + src.imm;
            OP_MUL:   alu_res = mul_result;
            default:  alu_res = '0;
        endcase
    end

    assign flags_upd = !stall && (updates_flags(src.opcode) || (is_mul && mul_done));

    always_comb begin
        ctrl_d   = src.ctrl;
        result_d = alu_res;
        store_d  = op_b;
        if (stall) begin
            ctrl_d   = CTRL_BUBBLE;
            result_d = '0;
            store_d  = '0;
        end

        nvz_d = nvz_q;
        if (flags_upd) begin
            nvz_d[NVZ_N] = alu_res[15];
            nvz_d[NVZ_V] = ovf;
            nvz_d[NVZ_Z] = (alu_res == '0);
        end
    end

    // Capture forwarded operands so the replay sees values no longer on the bypass.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (load_use || mul_start) begin
            hold_d       = src;
            hold_d.data1 = op_a;
            hold_d.data2 = op_b;
            hold_valid_d = 1'b1;
        end else if (!mul_busy || mul_done) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            ctrl_q       <= CTRL_BUBBLE;
            result_q     <= '0;
            store_q      <= '0;
            nvz_q        <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            store_q      <= store_d;
            nvz_q        <= nvz_d;
        end
    end

    // NOTE: the buffer payload is not reset; hold_valid_q decides whether it is ever read.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign oNVZ           = nvz_q;
    assign oAluResult     = result_q;
    assign oStoreData     = store_q;
    assign oAlutoReg      = ctrl_q.alu_to_reg;
    assign oMemtoReg      = ctrl_q.mem_to_reg;
    assign oBustoReg      = ctrl_q.bus_to_reg;
    assign oWriteBackAddr = ctrl_q.wb_addr;
    assign oMemRead       = ctrl_q.mem_read;
    assign oMemWrite      = ctrl_q.mem_write;
    assign oBusWrite      = ctrl_q.bus_write;

endmodule
